// File: rtl/paddle_array_ctrl.sv
// Paddle controller for N players. Raw active-low buttons are synchronised
// and debounced. Paddles move once per prescaled tick and speed up after a
// sustained same-direction hold. Positions clamp to the playfield. The game
// state decides which paddles may move, and state 3 re-centres every paddle.
module paddle_array_ctrl #(
  parameter int N_PLAYERS  = 2,
  parameter int POS_W      = 10,
  parameter int POS_MIN    = 140,
  parameter int POS_MAX    = 340,
  parameter int CENTER     = 220,
  parameter int STEP       = 10,
  parameter int FAST_STEP  = 20,
  parameter int HOLD_TICKS = 8,
  parameter int TICK_DIV   = 250000,
  parameter int DEB_CYCLES = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [1:0]                 game_state,
  input  logic [N_PLAYERS-1:0]       up_n,
  input  logic [N_PLAYERS-1:0]       down_n,
  output logic [N_PLAYERS*POS_W-1:0] pos,
  output logic [N_PLAYERS-1:0]       at_limit,
  output logic [N_PLAYERS-1:0]       moving
);

  localparam int PRE_W  = $clog2(TICK_DIV);
  localparam int DEB_W  = $clog2(DEB_CYCLES + 1);
  localparam int HOLD_W = (HOLD_TICKS < 1) ? 1 : $clog2(HOLD_TICKS + 1);

  localparam logic [PRE_W-1:0]  TICK_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(HOLD_TICKS);
  localparam logic [POS_W-1:0]  CENTER_P  = POS_W'(CENTER);
  localparam logic [POS_W-1:0]  MIN_P     = POS_W'(POS_MIN);
  localparam logic [POS_W-1:0]  MAX_P     = POS_W'(POS_MAX);
  localparam logic [POS_W:0]    MIN_X     = (POS_W+1)'(POS_MIN);
  localparam logic [POS_W:0]    MAX_X     = (POS_W+1)'(POS_MAX);
  localparam logic [POS_W:0]    STEP_X    = (POS_W+1)'(STEP);
  localparam logic [POS_W:0]    FAST_X    = (POS_W+1)'(FAST_STEP);

  // Up move with a floor at POS_MIN. The compare is one bit wider so it cannot wrap.
  function automatic logic [POS_W-1:0] sat_up(input logic [POS_W-1:0] p,
                                               input logic [POS_W:0]   s);
    logic [POS_W:0] ext;
    ext = {1'b0, p};
    if (ext < MIN_X + s) return MIN_P;
    return p - s[POS_W-1:0];
  endfunction

  // Down move with a ceiling at POS_MAX. The sum is one bit wider so it cannot wrap.
  function automatic logic [POS_W-1:0] sat_dn(input logic [POS_W-1:0] p,
                                               input logic [POS_W:0]   s);
    logic [POS_W:0] sum;
    sum = {1'b0, p} + s;
    if (sum > MAX_X) return MAX_P;
    return sum[POS_W-1:0];
  endfunction

  logic [PRE_W-1:0]       presc;
  logic                   tick;
  // Button vectors: the low N bits hold the up buttons, the high N bits hold the down buttons.
  logic [2*N_PLAYERS-1:0] btn_meta_p0;
  logic [2*N_PLAYERS-1:0] btn_sync_p1;
  logic [2*N_PLAYERS-1:0] deb_q;
  logic [DEB_W-1:0]       deb_cnt [2*N_PLAYERS];
  logic [POS_W-1:0]       pos_q   [N_PLAYERS];
  logic [POS_W-1:0]       pos_nxt [N_PLAYERS];
  logic [HOLD_W-1:0]      hold_q  [N_PLAYERS];
  logic [POS_W:0]         step    [N_PLAYERS];
  logic [N_PLAYERS-1:0]   dir_vld_q, dir_up_q;
  logic [N_PLAYERS-1:0]   allowed, req_up, req_dn, has_req, dir_chg;

  // Free-running move prescaler. It does not depend on the game state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) presc <= '0;
    else if (presc == TICK_LAST) presc <= '0;
    else presc <= presc + PRE_W'(1);
  end

  assign tick = (presc == TICK_LAST);

  // Two-flop synchroniser, then a per-button stability counter for the debounced level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_meta_p0 <= '1;
      btn_sync_p1 <= '1;
      deb_q       <= '1;
      for (int i = 0; i < 2*N_PLAYERS; i++) deb_cnt[i] <= '0;
    end else begin
      btn_meta_p0 <= {down_n, up_n};
      btn_sync_p1 <= btn_meta_p0;
      for (int i = 0; i < 2*N_PLAYERS; i++) begin
        if (btn_sync_p1[i] == deb_q[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          deb_q[i]   <= btn_sync_p1[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
        end
      end
    end
  end

  // Move permission from the game state: state 0 serves P0, state 1 serves P1, state 2 frees everyone.
  always_comb begin
    allowed = '0;
    case (game_state)
      2'd0:    allowed = N_PLAYERS'(1);
      2'd1:    allowed = N_PLAYERS'(2);
      2'd2:    allowed = '1;
      default: allowed = '0;
    endcase
  end

  // Request decode, step size and clamped candidate position for each player.
  always_comb begin
    req_up  = '0;
    req_dn  = '0;
    has_req = '0;
    dir_chg = '0;
    for (int i = 0; i < N_PLAYERS; i++) begin
      req_up[i]  = !deb_q[i] && deb_q[N_PLAYERS+i];
      req_dn[i]  = deb_q[i] && !deb_q[N_PLAYERS+i];
      has_req[i] = req_up[i] | req_dn[i];
      dir_chg[i] = has_req[i] && dir_vld_q[i] && (dir_up_q[i] != req_up[i]);
      step[i]    = (!dir_chg[i] && (hold_q[i] >= HOLD_SAT)) ? FAST_X : STEP_X;
      pos_nxt[i] = req_up[i] ? sat_up(pos_q[i], step[i]) : sat_dn(pos_q[i], step[i]);
    end
  end

  // Position, hold counter and last direction. State 3 re-centres at once without waiting for a tick.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dir_vld_q <= '0;
      dir_up_q  <= '0;
      for (int i = 0; i < N_PLAYERS; i++) begin
        pos_q[i]  <= CENTER_P;
        hold_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_PLAYERS; i++) begin
        if (game_state == 2'd3) begin
          pos_q[i]     <= CENTER_P;
          hold_q[i]    <= '0;
          dir_vld_q[i] <= 1'b0;
          dir_up_q[i]  <= 1'b0;
        end else begin
          if (!allowed[i] || !has_req[i] || dir_chg[i]) hold_q[i] <= '0;
          else if (tick && (hold_q[i] != HOLD_SAT)) hold_q[i] <= hold_q[i] + HOLD_W'(1);
          if (tick && allowed[i] && has_req[i]) begin
            pos_q[i]     <= pos_nxt[i];
            dir_vld_q[i] <= 1'b1;
            dir_up_q[i]  <= req_up[i];
          end
        end
      end
    end
  end

  // Flattened positions, limit flags and movement flags for the downstream logic.
  for (genvar g = 0; g < N_PLAYERS; g++) begin : g_out
    assign pos[g*POS_W +: POS_W] = pos_q[g];
    assign at_limit[g] = (pos_q[g] == MIN_P) || (pos_q[g] == MAX_P);
    assign moving[g]   = allowed[g] && has_req[g];
  end

endmodule

// File: tb/tb_paddle_array_ctrl.sv
// Directed bench for paddle_array_ctrl using TICK_DIV=4, DEB_CYCLES=3, HOLD_TICKS=2.
module tb_paddle_array_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  game_state = 2'd2;
  logic [1:0]  up_n = 2'b11;
  logic [1:0]  down_n = 2'b11;
  logic [19:0] pos;
  logic [1:0]  at_limit;
  logic [1:0]  moving;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  paddle_array_ctrl #(
    .N_PLAYERS(2), .POS_W(10), .POS_MIN(140), .POS_MAX(340), .CENTER(220),
    .STEP(10), .FAST_STEP(20), .HOLD_TICKS(2), .TICK_DIV(4), .DEB_CYCLES(3)
  ) dut (
    .clk(clk), .reset(reset), .game_state(game_state), .up_n(up_n),
    .down_n(down_n), .pos(pos), .at_limit(at_limit), .moving(moving)
  );

  always #5 clk = ~clk;

  // Cycles since reset release. Positions only change on edges where cyc % 4 == 0.
  always @(posedge clk or negedge reset) begin
    if (!reset) cyc <= 0;
    else cyc <= cyc + 1;
  end

  typedef struct {
    logic       rst;
    logic [1:0] gs;
    logic [1:0] up;
    logic [1:0] dn;
    int         ticks;
    int         p0;
    int         p1;
    logic [1:0] lim;
    logic [1:0] mv;
    string      name;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    up_n = 2'b11;
    down_n = 2'b11;
    game_state = 2'd2;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Advance to just after the next edge on which a tick can move a paddle.
  task automatic wait_tick();
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while ((cyc % 4) != 0 && n < 8);
  endtask

  task automatic check_all(input string nm, input int p0, input int p1,
                           input logic [1:0] lim, input logic [1:0] mv);
    check({nm, ".p0"}, int'(pos[9:0]), p0);
    check({nm, ".p1"}, int'(pos[19:10]), p1);
    check({nm, ".lim"}, int'(at_limit), int'(lim));
    check({nm, ".mv"}, int'(moving), int'(mv));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen_bad;

    // Each row drives its inputs, waits the given number of ticks, then checks.
    // Inputs change right after a move edge, so a new press first moves two ticks later.
    // P0 holds up: it accelerates and then clamps.
    tbl.push_back('{1'b1, 2'd2, 2'b11, 2'b11, 1, 220, 220, 2'b00, 2'b00, "rst_idle"});
    tbl.push_back('{1'b0, 2'd2, 2'b10, 2'b11, 2, 210, 220, 2'b00, 2'b01, "up_t1"});
    tbl.push_back('{1'b0, 2'd2, 2'b10, 2'b11, 1, 200, 220, 2'b00, 2'b01, "up_t2"});
    tbl.push_back('{1'b0, 2'd2, 2'b10, 2'b11, 1, 180, 220, 2'b00, 2'b01, "up_fast1"});
    tbl.push_back('{1'b0, 2'd2, 2'b10, 2'b11, 1, 160, 220, 2'b00, 2'b01, "up_fast2"});
    tbl.push_back('{1'b0, 2'd2, 2'b10, 2'b11, 1, 140, 220, 2'b01, 2'b01, "up_clamp"});
    tbl.push_back('{1'b0, 2'd2, 2'b10, 2'b11, 1, 140, 220, 2'b01, 2'b01, "up_hold_min"});
    // Serve states: only the serving player moves.
    tbl.push_back('{1'b1, 2'd0, 2'b11, 2'b00, 2, 230, 220, 2'b00, 2'b01, "s0_t1"});
    tbl.push_back('{1'b0, 2'd0, 2'b11, 2'b00, 1, 240, 220, 2'b00, 2'b01, "s0_t2"});
    tbl.push_back('{1'b0, 2'd0, 2'b11, 2'b00, 1, 260, 220, 2'b00, 2'b01, "s0_fast"});
    tbl.push_back('{1'b0, 2'd0, 2'b11, 2'b00, 1, 280, 220, 2'b00, 2'b01, "s0_fast2"});
    tbl.push_back('{1'b0, 2'd1, 2'b11, 2'b00, 1, 280, 230, 2'b00, 2'b10, "s1_t1"});
    tbl.push_back('{1'b0, 2'd1, 2'b11, 2'b00, 1, 280, 240, 2'b00, 2'b10, "s1_t2"});
    tbl.push_back('{1'b0, 2'd1, 2'b11, 2'b00, 1, 280, 260, 2'b00, 2'b10, "s1_fast"});
    // P1 first presses both buttons, then holds down, then reverses directly to up.
    tbl.push_back('{1'b1, 2'd2, 2'b01, 2'b01, 3, 220, 220, 2'b00, 2'b00, "both"});
    tbl.push_back('{1'b0, 2'd2, 2'b11, 2'b01, 2, 220, 230, 2'b00, 2'b10, "dn_t1"});
    tbl.push_back('{1'b0, 2'd2, 2'b11, 2'b01, 1, 220, 240, 2'b00, 2'b10, "dn_t2"});
    tbl.push_back('{1'b0, 2'd2, 2'b11, 2'b01, 1, 220, 260, 2'b00, 2'b10, "dn_fast1"});
    tbl.push_back('{1'b0, 2'd2, 2'b11, 2'b01, 1, 220, 280, 2'b00, 2'b10, "dn_fast2"});
    tbl.push_back('{1'b0, 2'd2, 2'b11, 2'b01, 1, 220, 300, 2'b00, 2'b10, "dn_fast3"});
    tbl.push_back('{1'b0, 2'd2, 2'b01, 2'b11, 1, 220, 320, 2'b00, 2'b10, "rev_pending"});
    tbl.push_back('{1'b0, 2'd2, 2'b01, 2'b11, 1, 220, 310, 2'b00, 2'b10, "rev_first"});
    tbl.push_back('{1'b0, 2'd2, 2'b01, 2'b11, 1, 220, 300, 2'b00, 2'b10, "rev_second"});
    // Drive both paddles to opposite limits ahead of the re-centre check.
    tbl.push_back('{1'b1, 2'd2, 2'b01, 2'b10, 2, 230, 210, 2'b00, 2'b11, "lim_t1"});
    tbl.push_back('{1'b0, 2'd2, 2'b01, 2'b10, 6, 340, 140, 2'b11, 2'b11, "lim_both"});

    foreach (tbl[k]) begin
      if (tbl[k].rst) do_reset();
      game_state = tbl[k].gs;
      up_n       = tbl[k].up;
      down_n     = tbl[k].dn;
      repeat (tbl[k].ticks) wait_tick();
      check_all(tbl[k].name, tbl[k].p0, tbl[k].p1, tbl[k].lim, tbl[k].mv);
    end

    // State 3: moving drops at once and positions re-centre on the next edge, which is not a tick edge.
    game_state = 2'd3;
    #1;
    check("done.mv_now", int'(moving), 0);
    @(posedge clk);
    #1;
    check("done.notick", cyc % 4, 1);
    check_all("done.center", 220, 220, 2'b00, 2'b00);
    repeat (12) @(posedge clk);
    #1;
    check_all("done.held", 220, 220, 2'b00, 2'b00);
    game_state = 2'd2;
    wait_tick();
    check_all("resume", 230, 210, 2'b00, 2'b11);

    // Reset asserted mid-hold forces the centre without any clock edge.
    do_reset();
    up_n = 2'b10;
    repeat (3) wait_tick();
    check("hold.pre", int'(pos[9:0]), 200);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check_all("async_rst", 220, 220, 2'b00, 2'b00);
    @(negedge clk);
    reset = 1'b1;

    // A two-cycle glitch is shorter than the debounce window and must be ignored.
    do_reset();
    up_n = 2'b10;
    @(posedge clk);
    @(posedge clk);
    #1;
    up_n = 2'b11;
    seen_bad = 1'b0;
    for (int c = 0; c < 24; c++) begin
      @(posedge clk);
      #1;
      if (moving[0] || pos[9:0] != 10'd220) seen_bad = 1'b1;
    end
    check("glitch.any_move", int'(seen_bad), 0);
    check_all("glitch.end", 220, 220, 2'b00, 2'b00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
